// File: rtl/wb_mem_ctrl_pkg.sv
// Shared opcode/funct3 constants, FSM encoding and decode helpers for the
// writeback/memory-phase controller.
package wb_mem_ctrl_pkg;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  localparam logic [2:0] F3Byte  = 3'b000;
  localparam logic [2:0] F3Half  = 3'b001;
  localparam logic [2:0] F3Word  = 3'b010;
  localparam logic [2:0] F3ByteU = 3'b100;
  localparam logic [2:0] F3HalfU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StMem,
    StWb
  } state_e;

  typedef enum logic [1:0] {
    ClsNone,
    ClsAlu,
    ClsMem,
    ClsMisalign
  } cls_e;

  // Branches, unknown opcodes and unsupported load/store sizes fall into ClsNone.
  function automatic cls_e classify(logic [6:0] op, logic [2:0] f3, logic [1:0] lane);
    cls_e cls;
    cls = ClsNone;
    case (op)
      OpLui, OpAuipc, OpJal, OpJalr, OpOpImm, OpOp: cls = ClsAlu;
      OpLoad, OpStore: begin
        if (f3 == F3Byte || (op == OpLoad && f3 == F3ByteU)) begin
          cls = ClsMem;
        end else if (f3 == F3Half || (op == OpLoad && f3 == F3HalfU)) begin
          cls = lane[0] ? ClsMisalign : ClsMem;
        end else if (f3 == F3Word) begin
          cls = (lane != 2'b00) ? ClsMisalign : ClsMem;
        end
      end
      default: cls = ClsNone;
    endcase
    return cls;
  endfunction

  function automatic logic [3:0] lane_be(logic [2:0] f3, logic [1:0] lane);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = 4'b0011 << lane;
      default: be = 4'hF;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(logic [2:0] f3, logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data lane selection with sign or zero extension.
module load_extend
  import wb_mem_ctrl_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {lane_i, 3'b000};
    case (funct3_i)
      F3Byte:  data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3Half:  data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3ByteU: data_o = {24'h0, shifted[7:0]};
      F3HalfU: data_o = {16'h0, shifted[15:0]};
      default: data_o = shifted;  // word loads are always lane 0
    endcase
  end

endmodule

// File: rtl/wb_mem_ctrl.sv
// Writeback / data-memory phase controller: issues one data-memory access per
// load/store, extends load data and drives the register-file write port.
module wb_mem_ctrl
  import wb_mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_err,
  output logic        timeout_err
);

  localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mis_q, mis_d;
  logic            to_q, to_d;

  logic [6:0]  op_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic [31:0] addr_q;
  logic [31:0] sdata_q;
  logic [31:0] rdata_q;
  logic [31:0] ld_data;
  logic        fire;

  assign fire = issue_valid && issue_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    mis_d   = 1'b0;
    to_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fire) begin
          case (classify(opcode, funct3, alu_result[1:0]))
            ClsAlu:      state_d = StWb;
            ClsMem:      state_d = StMem;
            ClsMisalign: mis_d   = 1'b1;
            default:     state_d = StIdle;
          endcase
        end
      end
      StMem: begin
        // An ack in the final counted cycle still completes the access.
        if (dmem_ack) begin
          state_d = (op_q == OpLoad) ? StWb : StIdle;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          state_d = StIdle;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (fire) begin
        op_q    <= opcode;
        f3_q    <= funct3;
        rd_q    <= rd;
        addr_q  <= alu_result;
        sdata_q <= store_data;
      end
      if (state_q == StMem && dmem_ack) begin
        rdata_q <= dmem_rdata;
      end
    end
  end

  load_extend u_load_extend (
    .funct3_i (f3_q),
    .lane_i   (addr_q[1:0]),
    .rdata_i  (rdata_q),
    .data_o   (ld_data)
  );

  always_comb begin
    issue_ready  = (state_q == StIdle);
    dmem_req     = (state_q == StMem);
    dmem_we      = dmem_req && (op_q == OpStore);
    dmem_addr    = dmem_req ? addr_q : '0;
    dmem_be      = dmem_req ? lane_be(f3_q, addr_q[1:0]) : '0;
    dmem_wdata   = dmem_we ? store_wdata(f3_q, sdata_q) : '0;
    wb_en        = (state_q == StWb) && (rd_q != 5'd0);
    wb_rd        = wb_en ? rd_q : '0;
    wb_data      = '0;
    if (wb_en) begin
      wb_data = (op_q == OpLoad) ? ld_data : addr_q;
    end
    misalign_err = mis_q;
    timeout_err  = to_q;
  end

endmodule

// File: tb/tb_wb_mem_ctrl.sv
// Randomised bench for wb_mem_ctrl: a transaction-level model predicts every
// cycle's outputs, plus directed literal checks of the key scenarios.
module tb_wb_mem_ctrl;

  localparam int unsigned TMO = 4;
  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67;
  localparam logic [6:0] OPIMM = 7'h13, OP = 7'h33, LOAD = 7'h03, STORE = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rd = '0;
  logic [31:0] alu_result = '0;
  logic [31:0] store_data = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign_err, timeout_err;

  always #5 clk = ~clk;

  wb_mem_ctrl #(.TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .opcode       (opcode),
    .funct3       (funct3),
    .rd           (rd),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .misalign_err (misalign_err),
    .timeout_err  (timeout_err)
  );

  typedef struct packed {
    logic        ready;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mis;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  bit   chk_en = 1'b0;
  int   total = 0;
  int   passed = 0;

  int          n_req, n_wb, n_mis, n_to, n_busy;
  logic [31:0] last_wb_data, last_wdata;
  logic [4:0]  last_wb_rd;
  logic [3:0]  last_be;
  logic        last_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e = '0;
    e.ready = 1'b1;
    return e;
  endfunction

  // 0 = no effect, 1 = register writeback, 2 = memory access, 3 = misaligned
  function automatic int kind_of(logic [6:0] op, logic [2:0] f3, logic [31:0] a);
    int size;
    if (op == LUI || op == AUIPC || op == JAL || op == JALR || op == OPIMM || op == OP) return 1;
    if (op != LOAD && op != STORE) return 0;
    size = 0;
    if (f3 == 3'd0 || (op == LOAD && f3 == 3'd4)) size = 1;
    if (f3 == 3'd1 || (op == LOAD && f3 == 3'd5)) size = 2;
    if (f3 == 3'd2) size = 4;
    if (size == 0) return 0;
    return ((int'(a[1:0]) % size) != 0) ? 3 : 2;
  endfunction

  function automatic logic [31:0] load_model(logic [2:0] f3, logic [31:0] a, logic [31:0] d);
    logic [31:0] v;
    v = d >> (8 * int'(a[1:0]));
    case (f3)
      3'd0:    return v[7] ? ((v & 32'hFF) | 32'hFFFF_FF00) : (v & 32'hFF);
      3'd1:    return v[15] ? ((v & 32'hFFFF) | 32'hFFFF_0000) : (v & 32'hFFFF);
      3'd4:    return v & 32'hFF;
      3'd5:    return v & 32'hFFFF;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] be_model(logic [2:0] f3, logic [31:0] a);
    if (f3 == 3'd0) return 4'(1 << int'(a[1:0]));
    if (f3 == 3'd1) return 4'(3 << int'(a[1:0]));
    return 4'hF;
  endfunction

  function automatic logic [31:0] wdata_model(logic [2:0] f3, logic [31:0] d);
    if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  always begin : compare
    exp_t e;
    @(posedge clk);
    #2;
    if (chk_en) begin
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = idle_exp();
      chk("issue_ready", 32'(issue_ready), 32'(e.ready));
      chk("dmem_req", 32'(dmem_req), 32'(e.req));
      chk("wb_en", 32'(wb_en), 32'(e.wb_en));
      chk("misalign_err", 32'(misalign_err), 32'(e.mis));
      chk("timeout_err", 32'(timeout_err), 32'(e.to));
      if (e.req) begin
        chk("dmem_we", 32'(dmem_we), 32'(e.we));
        chk("dmem_addr", dmem_addr, e.addr);
        if (e.we) begin
          chk("dmem_be", 32'(dmem_be), 32'(e.be));
          chk("dmem_wdata", dmem_wdata, e.wdata);
        end
      end
      if (e.wb_en) begin
        chk("wb_rd", 32'(wb_rd), 32'(e.wb_rd));
        chk("wb_data", wb_data, e.wb_data);
      end
      if (dmem_req) begin
        n_req++;
        last_be = dmem_be;
        last_wdata = dmem_wdata;
        last_we = dmem_we;
      end
      if (wb_en) begin
        n_wb++;
        last_wb_data = wb_data;
        last_wb_rd = wb_rd;
      end
      if (misalign_err) n_mis++;
      if (timeout_err) n_to++;
      if (!issue_ready) n_busy++;
    end
  end

  task automatic obs_clear();
    n_req = 0; n_wb = 0; n_mis = 0; n_to = 0; n_busy = 0;
    last_wb_data = '0; last_wdata = '0; last_wb_rd = '0; last_be = '0; last_we = 1'b0;
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  task automatic scramble(input bit busy);
    issue_valid = busy ? 1'($urandom_range(0, 1)) : 1'b0;
    opcode = 7'($urandom);
    funct3 = 3'($urandom);
    rd = 5'($urandom);
    alu_result = $urandom;
    store_data = $urandom;
  endtask

  // ack_at: MEM cycle (1..TMO) in which the memory acknowledges, 0 = never
  task automatic run_txn(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd_v,
                         input logic [31:0] alu, input logic [31:0] sd, input int ack_at,
                         input logic [31:0] rdat);
    exp_t e, mem_e;
    int   kind;
    bit   is_ld;
    kind = kind_of(op, f3, alu);
    is_ld = (op == LOAD);
    mem_e = idle_exp();
    mem_e.ready = 1'b0;
    mem_e.req = 1'b1;
    mem_e.we = !is_ld;
    mem_e.addr = alu;
    if (!is_ld) begin
      mem_e.be = be_model(f3, alu);
      mem_e.wdata = wdata_model(f3, sd);
    end
    @(negedge clk);
    issue_valid = 1'b1;
    opcode = op; funct3 = f3; rd = rd_v; alu_result = alu; store_data = sd;
    dmem_ack = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    e = idle_exp();
    if (kind == 1) begin
      e.ready = 1'b0; e.wb_en = (rd_v != 0); e.wb_rd = rd_v; e.wb_data = alu;
    end else if (kind == 2) begin
      e = mem_e;
    end else if (kind == 3) begin
      e.mis = 1'b1;
    end
    exp_q.push_back(e);
    if (kind == 2) begin
      for (int j = 1; j <= int'(TMO); j++) begin
        @(negedge clk);
        scramble(1'b1);
        dmem_ack = (j == ack_at);
        dmem_rdata = (j == ack_at) ? rdat : $urandom;
        if (j == ack_at) begin
          if (is_ld) begin
            e = idle_exp();
            e.ready = 1'b0; e.wb_en = (rd_v != 0); e.wb_rd = rd_v;
            e.wb_data = load_model(f3, alu, rdat);
            exp_q.push_back(e);
            @(negedge clk);
            scramble(1'b1);
            dmem_ack = 1'($urandom_range(0, 1));
          end
          exp_q.push_back(idle_exp());
          break;
        end else if (j == int'(TMO)) begin
          e = idle_exp();
          e.to = 1'b1;
          exp_q.push_back(e);
        end else begin
          exp_q.push_back(mem_e);
        end
      end
    end else begin
      @(negedge clk);
      scramble(kind == 1);
      dmem_ack = 1'($urandom_range(0, 1));
      exp_q.push_back(idle_exp());
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1);
  end

  initial begin : stim
    obs_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    settle();
    chk("reset issue_ready", 32'(issue_ready), 32'd1);
    chk("reset dmem_req", 32'(dmem_req), 32'd0);
    chk("reset wb_en", 32'(wb_en), 32'd0);
    chk("reset misalign_err", 32'(misalign_err), 32'd0);
    chk("reset timeout_err", 32'(timeout_err), 32'd0);
    chk_en = 1'b1;

    obs_clear();
    run_txn(OP, 3'd0, 5'd5, 32'h1234, 32'h0, 0, 32'h0);
    settle();
    chk("op wb count", n_wb, 1);
    chk("op wb_rd", 32'(last_wb_rd), 32'd5);
    chk("op wb_data", last_wb_data, 32'h1234);
    chk("op busy cycles", n_busy, 1);

    obs_clear();
    run_txn(LOAD, 3'd0, 5'd9, 32'h103, 32'h0, 3, 32'h80FF_0000);
    settle();
    chk("lb wb_data", last_wb_data, 32'hFFFF_FF80);
    chk("lb req cycles", n_req, 3);

    obs_clear();
    run_txn(LOAD, 3'd4, 5'd9, 32'h103, 32'h0, 3, 32'h80FF_0000);
    settle();
    chk("lbu wb_data", last_wb_data, 32'h0000_0080);

    obs_clear();
    run_txn(STORE, 3'd1, 5'd4, 32'h202, 32'hAAAA_BEEF, 1, 32'h0);
    settle();
    chk("sh be", 32'(last_be), 32'hC);
    chk("sh wdata", last_wdata, 32'hBEEF_BEEF);
    chk("sh we", 32'(last_we), 32'd1);
    chk("sh no wb", n_wb, 0);

    obs_clear();
    run_txn(LOAD, 3'd2, 5'd6, 32'h101, 32'h0, 1, 32'h0);
    settle();
    chk("lw misalign pulse", n_mis, 1);
    chk("lw misalign no req", n_req, 0);
    chk("lw misalign busy", n_busy, 0);

    obs_clear();
    run_txn(LOAD, 3'd2, 5'd6, 32'h100, 32'h0, 0, 32'h0);
    settle();
    chk("timeout req cycles", n_req, 4);
    chk("timeout pulse", n_to, 1);
    chk("timeout no wb", n_wb, 0);

    obs_clear();
    run_txn(LOAD, 3'd2, 5'd3, 32'h104, 32'h0, 4, 32'h1357_9BDF);
    settle();
    chk("late ack no timeout", n_to, 0);
    chk("late ack wb", n_wb, 1);
    chk("late ack data", last_wb_data, 32'h1357_9BDF);

    obs_clear();
    run_txn(LUI, 3'd0, 5'd0, 32'hDEAD_0000, 32'h0, 0, 32'h0);
    settle();
    chk("rd0 no wb", n_wb, 0);
    chk("rd0 busy", n_busy, 1);

    // Reset in the middle of a memory access
    chk_en = 1'b0;
    @(negedge clk);
    issue_valid = 1'b1; opcode = LOAD; funct3 = 3'd2; rd = 5'd9; alu_result = 32'h300;
    dmem_ack = 1'b0;
    @(negedge clk);
    issue_valid = 1'b0;
    @(negedge clk);
    chk("pre-reset dmem_req", 32'(dmem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("reset dmem_req drop", 32'(dmem_req), 32'd0);
    chk("reset wb_en", 32'(wb_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dmem_ack = 1'b1;
    settle();
    chk("post-reset issue_ready", 32'(issue_ready), 32'd1);
    chk("post-reset dmem_req", 32'(dmem_req), 32'd0);
    chk("post-reset wb_en", 32'(wb_en), 32'd0);
    dmem_ack = 1'b0;
    exp_q.delete();
    chk_en = 1'b1;
    obs_clear();
    run_txn(LUI, 3'd0, 5'd7, 32'hCAFE_0000, 32'h0, 0, 32'h0);
    settle();
    chk("post-reset lui wb", n_wb, 1);
    chk("post-reset lui data", last_wb_data, 32'hCAFE_0000);

    for (int t = 0; t < 200; t++) begin
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [31:0] a;
      int          ack_at;
      f3 = 3'($urandom);
      case ($urandom_range(0, 11))
        0: op = LUI;
        1: op = AUIPC;
        2: op = JAL;
        3: op = JALR;
        4: op = OPIMM;
        5: op = OP;
        6, 7: begin
          op = LOAD;
          case ($urandom_range(0, 4))
            0: f3 = 3'd0;
            1: f3 = 3'd1;
            2: f3 = 3'd2;
            3: f3 = 3'd4;
            default: f3 = 3'd5;
          endcase
        end
        8, 9: begin
          op = STORE;
          f3 = 3'($urandom_range(0, 2));
        end
        10: op = BRANCH;
        default: op = 7'h7F;
      endcase
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      ack_at = $urandom_range(0, 5);
      if (ack_at > int'(TMO)) ack_at = 0;
      run_txn(op, f3, 5'($urandom), a, $urandom, ack_at, $urandom);
    end
    settle();
    settle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
